// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult_seq
// Purpose  : Sequential radix-4 Booth multiplier. Each cycle in CALC retires
//            one Booth digit of the captured multiplier.
//            Products are full width and may be signed or unsigned.
//            An IDLE / CALC / DONE FSM wraps the datapath with valid/ready
//            handshakes on both sides.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   A_WIDTH     : multiplicand width, 4..32
//   B_WIDTH     : multiplier width, even, 4..32
// Ports
//   CLK         : in  - clock, rising edge
//   RST_N       : in  - asynchronous active-low reset
//   IN_VALID    : in  - A_NUM / B_NUM / SIGNED_MODE are valid
//   IN_READY    : out - high only in IDLE
//   A_NUM       : in  - multiplicand [A_WIDTH-1:0]
//   B_NUM       : in  - multiplier   [B_WIDTH-1:0]
//   SIGNED_MODE : in  - 1 = two's-complement operands, 0 = unsigned
//   OUT_VALID   : out - high only in DONE; C_NUM holds the product
//   OUT_READY   : in  - consumer takes C_NUM (leaves DONE)
//   C_NUM       : out - product [A_WIDTH+B_WIDTH-1:0]
//   BUSY        : out - high only in CALC
// Configuration
//   BOOTH_MULT_EARLY_TERM_EN : when defined, CALC ends as soon as every
//                              remaining Booth digit is zero.
// ============================================================================
module booth_mult_seq #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [A_WIDTH-1:0]         A_NUM,
    input  logic [B_WIDTH-1:0]         B_NUM,
    input  logic                       SIGNED_MODE,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [A_WIDTH+B_WIDTH-1:0] C_NUM,
    output logic                       BUSY
);

    localparam int C_P_W        = A_WIDTH + B_WIDTH;
    localparam int C_ACC_W      = C_P_W + 2;
    localparam int C_EXT_B_W    = B_WIDTH + 2;
    localparam int C_NUM_DIGITS = B_WIDTH / 2 + 1;
    localparam int C_CNT_W      = $clog2(C_NUM_DIGITS + 1);
    localparam logic [C_CNT_W-1:0] C_LAST_DIGIT = C_CNT_W'(C_NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    // The multiplicand is pre-extended to accumulator width and shifted left
    // by two each cycle. That gives the 2*digit_index weighting for free.
    logic [C_ACC_W-1:0]   mcand_q,     mcand_d;
    // The extended multiplier shifts right by two each cycle. Bits [1:0] are
    // always the current digit's upper bits. prev_q holds the bit just below.
    logic [C_EXT_B_W-1:0] mplier_q,    mplier_d;
    logic                 prev_q,      prev_d;
    logic [C_ACC_W-1:0]   acc_q,       acc_d;
    logic [C_CNT_W-1:0]   cnt_q,       cnt_d;
    logic [C_P_W-1:0]     c_num_q,     c_num_d;
    logic                 in_ready_q,  in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q,      busy_d;

    logic [2:0]           w_digit_bits;
    logic [C_ACC_W-1:0]   w_mcand_x2;
    logic [C_ACC_W-1:0]   w_pp;
    logic [C_ACC_W-1:0]   w_acc_sum;
    logic                 w_last_digit;

    // ------------------------------------------------------------------------
    // Booth digit decode and partial product
    // ------------------------------------------------------------------------
    assign w_digit_bits = {mplier_q[1:0], prev_q};
    assign w_mcand_x2   = mcand_q << 1;

    always_comb begin
        w_pp = '0;
        unique case (w_digit_bits)
            3'b000, 3'b111: w_pp = '0;                                 //  0
            3'b001, 3'b010: w_pp = mcand_q;                            // +1
            3'b011:         w_pp = w_mcand_x2;                         // +2
            3'b100:         w_pp = (~w_mcand_x2) + C_ACC_W'(1);        // -2
            3'b101, 3'b110: w_pp = (~mcand_q) + C_ACC_W'(1);           // -1
            default:        w_pp = '0;
        endcase
    end

    // Accumulation is modulo 2^C_ACC_W. The low C_P_W bits are the exact
    // product for both signed and unsigned operands. This includes the
    // full-scale and most-negative corner cases.
    assign w_acc_sum = acc_q + w_pp;

    // ------------------------------------------------------------------------
    // End-of-calculation detection
    // ------------------------------------------------------------------------
`ifdef BOOTH_MULT_EARLY_TERM_EN
    logic w_rest_zero;

    // After this cycle's digit, the remaining digits are built from
    // mplier_q[C_EXT_B_W-1:2] and the last examined bit mplier_q[1].
    // If all of these bits are equal, every remaining digit is zero.
    // The right shift replicates the MSB, so the vacated bits never break
    // this test.
    assign w_rest_zero  = (&mplier_q[C_EXT_B_W-1:1]) | ~(|mplier_q[C_EXT_B_W-1:1]);
    assign w_last_digit = (cnt_q == C_LAST_DIGIT) | w_rest_zero;
`else
    assign w_last_digit = (cnt_q == C_LAST_DIGIT);
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prev_d   = prev_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        c_num_d  = c_num_q;

        unique case (state_q)
            S_IDLE: begin
                if (IN_VALID && in_ready_q) begin
                    // The two extra bits carry the sign in signed mode,
                    // or zero in unsigned mode. After this, the datapath
                    // treats every operand as signed.
                    mcand_d  = {{(C_ACC_W - A_WIDTH){A_NUM[A_WIDTH-1] & SIGNED_MODE}}, A_NUM};
                    mplier_d = {{2{B_NUM[B_WIDTH-1] & SIGNED_MODE}}, B_NUM};
                    prev_d   = 1'b0;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_CALC;
                end
            end

            S_CALC: begin
                acc_d    = w_acc_sum;
                mcand_d  = mcand_q << 2;
                mplier_d = {{2{mplier_q[C_EXT_B_W-1]}}, mplier_q[C_EXT_B_W-1:2]};
                prev_d   = mplier_q[1];
                cnt_d    = cnt_q + C_CNT_W'(1);
                if (w_last_digit) begin
                    c_num_d = w_acc_sum[C_P_W-1:0];
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (OUT_READY) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The handshake outputs are registered from the next state. This
        // keeps them glitch-free and exactly aligned with the FSM state.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_CALC);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prev_q      <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            c_num_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prev_q      <= prev_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            c_num_q     <= c_num_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign BUSY      = busy_q;
    assign C_NUM     = c_num_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mult_seq
// Purpose  : Self-checking bench for booth_mult_seq (A_WIDTH = B_WIDTH = 8).
//            A transaction-level model predicts the handshake outputs and the
//            product on every cycle. Directed operations pin literal products
//            and latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mult_seq;

    localparam int AW = 8;
    localparam int BW = 8;
    localparam int PW = AW + BW;
    localparam int N  = BW / 2 + 1;
`ifdef BOOTH_MULT_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          CLK         = 1'b0;
    logic          RST_N       = 1'b1;
    logic          IN_VALID    = 1'b0;
    logic          IN_READY;
    logic [AW-1:0] A_NUM       = '0;
    logic [BW-1:0] B_NUM       = '0;
    logic          SIGNED_MODE = 1'b0;
    logic          OUT_VALID;
    logic          OUT_READY   = 1'b0;
    logic [PW-1:0] C_NUM;
    logic          BUSY;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    booth_mult_seq #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .A_NUM      (A_NUM),
        .B_NUM      (B_NUM),
        .SIGNED_MODE(SIGNED_MODE),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .C_NUM      (C_NUM),
        .BUSY       (BUSY)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Exact product by plain integer arithmetic.
    function automatic logic [PW-1:0] ref_prod(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                               input logic s);
        longint av;
        longint bv;
        longint p;
        av = s ? longint'($signed(a)) : longint'(a);
        bv = s ? longint'($signed(b)) : longint'(b);
        p  = av * bv;
        return p[PW-1:0];
    endfunction

    // Cycles from accept to OUT_VALID. The fixed build always takes N.
    // With early termination, the count runs to the most significant
    // non-zero Booth digit, with a minimum of 1.
    function automatic int ref_lat(input logic [BW-1:0] b, input logic s);
        logic [BW+2:0] e;
        int hi;
        int d;
        hi = 0;
        e  = {{2{s & b[BW-1]}}, b, 1'b0};
        for (int i = 0; i < N; i++) begin
            d = -2 * int'(e[2*i+2]) + int'(e[2*i+1]) + int'(e[2*i]);
            if (d != 0) hi = i;
        end
        return EARLY ? hi + 1 : N;
    endfunction

    // Transaction model: 0 = idle, 1 = calculating, 2 = result presented.
    int            m_phase = 0;
    int            m_left  = 0;
    logic [PW-1:0] m_res   = '0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_phase <= 0;
            m_left  <= 0;
        end else begin
            case (m_phase)
                0: if (IN_VALID) begin
                    m_phase <= 1;
                    m_left  <= ref_lat(B_NUM, SIGNED_MODE);
                    m_res   <= ref_prod(A_NUM, B_NUM, SIGNED_MODE);
                end
                1: begin
                    if (m_left == 1) m_phase <= 2;
                    m_left <= m_left - 1;
                end
                default: if (OUT_READY) m_phase <= 0;
            endcase
        end
    end

    // Compare process. It runs on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge CLK);
            chk("in_ready",  64'(IN_READY),  64'(m_phase == 0));
            chk("out_valid", 64'(OUT_VALID), 64'(m_phase == 2));
            chk("busy",      64'(BUSY),      64'(m_phase == 1));
            if (m_phase == 2) chk("c_num_model", 64'(C_NUM), 64'(m_res));
            if (!RST_N)       chk("c_num_rst",   64'(C_NUM), 64'd0);
        end
    end

    // Caller is positioned at posedge+2. Runs one operation and checks its
    // latency and product against literals. The operand inputs are
    // scrambled after the accept edge.
    task automatic do_op(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic s,
                         input logic [PW-1:0] exp_c, input int exp_lat, input string name,
                         input bit consume);
        int w;
        int lat;
        w   = 0;
        lat = 0;
        while (!IN_READY && w < 50) begin
            @(posedge CLK); #2;
            w++;
        end
        chk({name, "_ready"}, 64'(IN_READY), 64'd1);
        A_NUM = a; B_NUM = b; SIGNED_MODE = s; IN_VALID = 1'b1;
        @(posedge CLK); #2;
        IN_VALID    = 1'b0;
        A_NUM       = 8'($urandom);
        B_NUM       = 8'($urandom);
        SIGNED_MODE = 1'($urandom_range(0, 1));
        while (!OUT_VALID && lat < 40) begin
            @(posedge CLK); #2;
            lat++;
        end
        chk({name, "_lat"},  64'(lat),   64'(exp_lat));
        chk({name, "_cnum"}, 64'(C_NUM), 64'(exp_c));
        if (consume) begin
            OUT_READY = 1'b1;
            @(posedge CLK); #2;
            OUT_READY = 1'b0;
        end
    endtask

    logic [7:0] corner [4];

    initial begin
        corner[0] = 8'h00; corner[1] = 8'hFF; corner[2] = 8'h80; corner[3] = 8'h7F;

        // Power-up reset
        #1 RST_N = 1'b0;
        #1;
        chk("rst_in_ready",  64'(IN_READY),  64'd1);
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_busy",      64'(BUSY),      64'd0);
        chk("rst_c_num",     64'(C_NUM),     64'd0);
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b1;

        // Full-scale and most-negative products
        do_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 5,              "u_ff_ff", 1'b1);
        do_op(8'h80, 8'h80, 1'b1, 16'h4000, EARLY ? 4 : 5, "s_80_80", 1'b1);
        do_op(8'hFF, 8'h7F, 1'b1, 16'hFF81, EARLY ? 4 : 5, "s_ff_7f", 1'b1);

        // Result held in DONE with stray IN_VALID pulses
        do_op(8'h80, 8'h80, 1'b1, 16'h4000, EARLY ? 4 : 5, "hold", 1'b0);
        for (int i = 0; i < 10; i++) begin
            IN_VALID    = 1'(i % 2);
            A_NUM       = 8'($urandom);
            B_NUM       = 8'($urandom);
            SIGNED_MODE = 1'($urandom_range(0, 1));
            @(posedge CLK); #2;
            chk("hold_c_num",     64'(C_NUM),     64'h4000);
            chk("hold_in_ready",  64'(IN_READY),  64'd0);
            chk("hold_out_valid", 64'(OUT_VALID), 64'd1);
        end
        // Consume while IN_VALID is high: no accept in the same cycle
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        @(posedge CLK); #2;
        OUT_READY = 1'b0;
        IN_VALID  = 1'b0;
        chk("release_in_ready",  64'(IN_READY),  64'd1);
        chk("release_out_valid", 64'(OUT_VALID), 64'd0);
        chk("release_busy",      64'(BUSY),      64'd0);

        // Reset in the third CALC cycle
        A_NUM = 8'hC3; B_NUM = 8'hA5; SIGNED_MODE = 1'b1; IN_VALID = 1'b1;
        @(posedge CLK); #2;
        IN_VALID = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #2;
        RST_N = 1'b0;
        #1;
        chk("abort_in_ready",  64'(IN_READY),  64'd1);
        chk("abort_out_valid", 64'(OUT_VALID), 64'd0);
        chk("abort_busy",      64'(BUSY),      64'd0);
        chk("abort_c_num",     64'(C_NUM),     64'd0);
        @(posedge CLK); #2;
        RST_N = 1'b1;
        do_op(8'h03, 8'h05, 1'b0, 16'h000F, EARLY ? 2 : 5, "u_3_5", 1'b1);

        // Early-termination cases. The fixed build must stay at N.
        do_op(8'h37, 8'h00, 1'b0, 16'h0000, EARLY ? 1 : 5, "u_37_00", 1'b1);
        do_op(8'h37, 8'h01, 1'b0, 16'h0037, EARLY ? 1 : 5, "u_37_01", 1'b1);

        // Randomised traffic checked by the model
        for (int i = 0; i < 600; i++) begin
            int sel;
            IN_VALID    = 1'($urandom_range(0, 1));
            SIGNED_MODE = 1'($urandom_range(0, 1));
            OUT_READY   = ($urandom_range(0, 3) != 0);
            A_NUM       = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      B_NUM = 8'($urandom_range(0, 3));
            else if (sel == 1) B_NUM = corner[$urandom_range(0, 3)];
            else if (sel == 2) B_NUM = 8'hFF - 8'($urandom_range(0, 3));
            else               B_NUM = 8'($urandom);
            @(posedge CLK); #2;
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        repeat (10) @(posedge CLK);
        #2;
        chk("final_idle", 64'(IN_READY), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 SHALL have parameter A_WIDTH, default 8: multiplicand width; legal range 4..32.
REQ-002 SHALL have parameter B_WIDTH, default 8: multiplier width; even, legal range 4..32.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port IN_VALID, input, 1 bit: operands and mode are valid.
REQ-006 SHALL have port IN_READY, output, 1 bit: block can accept operands.
REQ-007 SHALL have port A_NUM, input, A_WIDTH bits: multiplicand.
REQ-008 SHALL have port B_NUM, input, B_WIDTH bits: multiplier.
REQ-009 SHALL have port SIGNED_MODE, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-010 SHALL have port OUT_VALID, output, 1 bit: C_NUM holds a finished product.
REQ-011 SHALL have port OUT_READY, input, 1 bit: consumer accepts C_NUM.
REQ-012 SHALL have port C_NUM, output, A_WIDTH+B_WIDTH bits: full-width product, signed or unsigned per captured mode.
REQ-013 SHALL have port BUSY, output, 1 bit: high in CALC state.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 IN_READY SHALL be high only in IDLE; OUT_VALID SHALL be high only in DONE.
REQ-016 In IDLE, IN_VALID && IN_READY SHALL capture A_NUM, B_NUM and SIGNED_MODE, clear the accumulator and move to CALC.
REQ-017 Captured operands SHALL be extended by 2 bits: sign-extended if SIGNED_MODE=1, zero-extended if 0.
REQ-018 The extended multiplier SHALL give N = B_WIDTH/2+1 radix-4 Booth digits in {-2,-1,0,+1,+2}; the implicit bit below the LSB is 0.
REQ-019 CALC SHALL retire exactly one Booth digit per cycle, least-significant first.
REQ-020 Each digit SHALL add its partial product, shifted left by 2*digit_index, into an accumulator of A_WIDTH+B_WIDTH+2 bits.
REQ-021 After the N-th digit the FSM SHALL enter DONE, so OUT_VALID rises N cycles after the accept edge (5 cycles for B_WIDTH=8).
REQ-022 C_NUM SHALL equal the accumulator's low A_WIDTH+B_WIDTH bits and SHALL hold stable while OUT_VALID is high.
REQ-023 In DONE, OUT_READY=1 SHALL return the FSM to IDLE at the next edge; otherwise the FSM SHALL stay in DONE indefinitely.
REQ-024 IN_VALID SHALL be ignored outside IDLE: no capture, no state change.
REQ-025 The block SHALL NOT accept a new operation in the same cycle a result is consumed; the next accept is earliest one cycle after leaving DONE.
REQ-026 Changes on A_NUM, B_NUM and SIGNED_MODE after capture SHALL NOT affect the result in flight.
REQ-027 Unsigned full-scale and signed most-negative operands SHALL produce exact products with no overflow.

Reset
REQ-028 RST_N low SHALL asynchronously force IDLE, IN_READY=1, OUT_VALID=0, BUSY=0, C_NUM=0, accumulator=0 and the digit counter to 0.
REQ-029 Reset asserted in CALC or DONE SHALL abort the operation with no result presented; the first accept after reset release SHALL behave as from power-up.

Configuration
REQ-030 Macro BOOTH_MULT_EARLY_TERM_EN, when defined, SHALL end CALC at the first cycle in which all remaining Booth digits are zero (remaining extended multiplier bits and the last examined bit all 0 or all 1) and enter DONE on the next edge.
REQ-031 With BOOTH_MULT_EARLY_TERM_EN, minimum latency SHALL be 1 cycle from the accept edge to OUT_VALID, and results SHALL be identical to the fixed-latency build.
REQ-032 Without BOOTH_MULT_EARLY_TERM_EN, latency SHALL always be exactly N cycles.

Verification (A_WIDTH=B_WIDTH=8)
REQ-033 SHALL test: unsigned 0xFF * 0xFF -> C_NUM=0xFE01, OUT_VALID 5 cycles after accept.
REQ-034 SHALL test: signed 0x80 * 0x80 (-128*-128) -> C_NUM=0x4000; signed 0xFF * 0x7F (-1*127) -> C_NUM=0xFF81.
REQ-035 SHALL test: OUT_READY held low 10 cycles in DONE -> C_NUM=0x4000 stable, IN_READY=0, IN_VALID pulses ignored; OUT_READY=1 -> IDLE next edge.
REQ-036 SHALL test: RST_N pulsed low in the 3rd CALC cycle -> all outputs at reset values immediately; next op 3*5 unsigned -> 0x000F.
REQ-037 SHALL test: with BOOTH_MULT_EARLY_TERM_EN, unsigned 0x37 * 0x00 -> 0x0000 with 1-cycle latency, and 0x37 * 0x01 -> 0x0037 with latency under 5; without the macro, both take 5 cycles.
